addsub_serial: RTL and testbench

Parametrised, multi-cycle signed adder/subtractor for the datapath. It processes a WIDTH-bit operation one 4-bit slice per cycle through a single shared slice adder. It adds optional saturation, carry-out and zero/negative flags, with valid/ready handshakes on input and output. It is used where area matters more than latency, for example in a future multi-cycle ALU path.

---
 rtl/addsub_pkg.sv | 11 +
 rtl/addsub_slice.sv | 17 +
 rtl/addsub_serial.sv | 114 +++++++++++
 tb/tb_addsub_serial.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM encoding, slice width and saturation helper for addsub_serial
package addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
  localparam int SLICE_W = 4;
  localparam int MAX_W = 128;
  function automatic logic [MAX_W-1:0] sat_val(input int w, input logic is_neg);
    logic [MAX_W-1:0] m;
    m = MAX_W'(1) << (w - 1);
    return is_neg ? m : m - MAX_W'(1);
  endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: 4-bit combinational adder exposing carry into and out of the top bit
module addsub_slice (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout,
  output logic       c3
);
  logic [3:0] w_lo;
  logic [1:0] w_hi;
  assign w_lo = {1'b0, a4[2:0]} + {1'b0, b4[2:0]} + {3'b0, cin};
  assign w_hi = {1'b0, a4[3]} + {1'b0, b4[3]} + {1'b0, w_lo[3]};
  assign s4   = {w_hi[0], w_lo[2:0]};
  assign cout = w_hi[1];
  assign c3   = w_lo[3];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle signed add/sub, one 4-bit slice per cycle, with saturation and flags
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             cout,
  output logic             zero,
  output logic             neg
);
  localparam int SLICES = WIDTH / SLICE_W;
  localparam int CW = $clog2(SLICES);

  if (WIDTH % SLICE_W != 0 || WIDTH < 8 || WIDTH > MAX_W) begin : g_bad_width
    $error("addsub_serial: WIDTH must be a multiple of 4 in the range 8..128");
  end

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_sub, r_sat, r_carry, r_ovfl, r_cout, r_zero, r_neg;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       w_a4, w_b4, w_s4;
  logic             w_co, w_c3, w_last, w_ov;
  logic [WIDTH-1:0] w_raw, w_fin;

  assign w_a4   = r_a[SLICE_W*r_cnt +: SLICE_W];
  assign w_b4   = r_b[SLICE_W*r_cnt +: SLICE_W] ^ {SLICE_W{r_sub}};
  assign w_last = r_cnt == CW'(SLICES - 1);
  assign w_ov   = w_c3 ^ w_co;
  assign w_raw  = {w_s4, r_res[WIDTH-SLICE_W-1:0]};
  assign w_fin  = (w_ov && r_sat) ? WIDTH'(sat_val(WIDTH, r_a[WIDTH-1])) : w_raw;

  addsub_slice u_slice (
    .a4  (w_a4),
    .b4  (w_b4),
    .cin (r_carry),
    .s4  (w_s4),
    .cout(w_co),
    .c3  (w_c3)
  );

  // next-state: accept in IDLE, run SLICES cycles in CALC, hold in DONE until consumed
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // operand latch, per-slice accumulation, and final saturation/flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_sat   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_ovfl  <= 1'b0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= sub;
      r_sat   <= sat;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == CALC) begin
      r_carry <= w_co;
      if (w_last) begin
        r_res  <= w_fin;
        r_ovfl <= w_ov;
        r_cout <= w_co;
        r_zero <= w_fin == '0;
        r_neg  <= w_fin[WIDTH-1];
      end else begin
        r_res[SLICE_W*r_cnt +: SLICE_W] <= w_s4;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign result    = r_res;
  assign ovfl      = r_ovfl;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed and randomized checks of addsub_serial against an arithmetic model
module tb_addsub_serial;
  logic        clk, rst_n, in_valid, in_ready, sub, sat, out_valid, out_ready;
  logic        ovfl, cout, zero, neg;
  logic [15:0] a, b, result;
  int          n_vec, n_err;

  addsub_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovfl(ovfl), .cout(cout), .zero(zero), .neg(neg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // exact-integer model: {result, ovfl, cout, zero, neg}
  function automatic logic [19:0] ref_model(input logic [15:0] x, y, input logic s, t);
    int ex;
    logic [15:0] r;
    logic ov, co;
    ex = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    co = s ? (x >= y) : (int'(x) + int'(y) > 65535);
    ov = ex > 32767 || ex < -32768;
    r  = (ov && t) ? (ex < 0 ? 16'h8000 : 16'h7FFF) : ex[15:0];
    return {r, ov, co, r == 16'h0, r[15]};
  endfunction

  task automatic start_op(input logic [15:0] ai, bi, input logic si, ti, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    a = ai; b = bi; sub = si; sat = ti; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    #23;
    n_vec++;
    if ({in_ready, out_valid, result, ovfl, cout, zero, neg} !== {2'b10, 16'h0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", {in_ready, out_valid, result, ovfl, cout, zero, neg}, {2'b10, 20'h0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [15:0] ta[7] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0005, 16'h0000};
    logic [15:0] tb[7] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0001};
    logic        ts[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        tt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [19:0] te[7] = '{{16'h2233, 4'b0000}, {16'h8000, 4'b1001}, {16'h7FFF, 4'b1000},
                           {16'h8000, 4'b1101}, {16'h7FFF, 4'b1100}, {16'h0000, 4'b0110},
                           {16'hFFFF, 4'b0001}};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start_op(ta[i], tb[i], ts[i], tt[i], lat);
      n_vec++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat);
      end
      n_vec++;
      if ({result, ovfl, cout, zero, neg} !== te[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, {result, ovfl, cout, zero, neg}, te[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); sat = 1'($urandom);
      in_valid = i[0] ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({in_ready, out_valid, result, ovfl, cout, zero, neg} !== {2'b01, 16'h2233, 4'b0000}) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got %h want %h", i, {in_ready, out_valid, result, ovfl, cout, zero, neg}, {2'b01, 16'h2233, 4'b0000});
      end
    end
    in_valid = 1'b0;
    finish_op();
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL backpressure_release: got %b want 10", {in_ready, out_valid});
    end
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL backpressure_no_latch: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid;
    int lat, seen;
    a = 16'h1234; b = 16'h1111; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, result, ovfl, cout, zero, neg} !== {2'b10, 16'h0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_mid_async: got %h want %h", {in_ready, out_valid, result, ovfl, cout, zero, neg}, {2'b10, 20'h0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; seen += int'(out_valid); end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_mid_no_output: got %0d valid cycles want 0", seen);
    end
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
    n_vec++;
    if ({lat[7:0], result, ovfl, cout, zero, neg} !== {8'd4, 16'h1000, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_mid_next_op: got %h want %h", {lat[7:0], result, ovfl, cout, zero, neg}, {8'd4, 16'h1000, 4'b0000});
    end
    finish_op();
  endtask

  task automatic test_random;
    logic [15:0] ai, bi;
    logic        si, ti;
    logic [19:0] exp;
    int lat;
    for (int i = 0; i < 500; i++) begin
      ai = 16'($urandom); bi = 16'($urandom); si = 1'($urandom); ti = 1'($urandom);
      if (i % 8 == 0) ai = {~bi[15], 15'($urandom)};
      exp = ref_model(ai, bi, si, ti);
      start_op(ai, bi, si, ti, lat);
      n_vec++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL random_latency[%0d]: got %0d want 4", i, lat);
      end
      n_vec++;
      if ({result, ovfl, cout, zero, neg} !== exp) begin
        n_err++;
        $display("FAIL random_result[%0d] a=%h b=%h sub=%b sat=%b: got %h want %h", i, ai, bi, si, ti, {result, ovfl, cout, zero, neg}, exp);
      end
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++;
      if ({out_valid, result, ovfl, cout, zero, neg} !== {1'b1, exp}) begin
        n_err++;
        $display("FAIL random_stable[%0d]: got %h want %h", i, {out_valid, result, ovfl, cout, zero, neg}, {1'b1, exp});
      end
      finish_op();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
